// File: rtl/sirali_toplayici.sv
// sirali_toplayici: sequential (chunk-serial) adder/subtractor.
//
// Adds or subtracts two WIDTH-bit operands CHUNK bits per clock through a
// single CHUNK-bit ripple slice. The carry between chunks lives in a register,
// so an operation takes N = WIDTH/CHUNK compute cycles plus one DONE cycle.
//
// Parameters:
//   WIDTH  operand/result width; must be a multiple of CHUNK
//   CHUNK  bits processed per clock (1 <= CHUNK <= WIDTH)
//
// Ports:
//   clk    clock, rising edge
//   rst    synchronous active-high reset
//   start  request, sampled only in IDLE or DONE
//   sub    0: A+B+Cin, 1: A-B (latched with start)
//   Cin    carry-in for add, ignored for subtract
//   A, B   operands (latched with start)
//   S      result, valid from done until the next accepted start
//   Cout   carry out of MSB (subtract: 1 = no borrow)
//   V      signed overflow
//   Z      result is zero
//   busy   high while chunks are being computed
//   done   one-cycle pulse when result and flags are valid
module sirali_toplayici #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             Cin,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V,
  output logic             Z,
  output logic             busy,
  output logic             done
);

  localparam int unsigned N    = WIDTH / CHUNK;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;  // already inverted for subtract
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             v_q, v_d;
  logic             z_q, z_d;

  // Ripple slice operating on the chunk selected by the counter.
  logic [IdxW-1:0]  chunk_lsb;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   chunk_sum;
  logic             msb_cin;
  logic             last_chunk;
  logic [WIDTH-1:0] s_calc;

  assign chunk_lsb  = IdxW'(32'(cnt_q) * CHUNK);
  assign a_chunk    = a_q[chunk_lsb +: CHUNK];
  assign b_chunk    = b_q[chunk_lsb +: CHUNK];
  assign chunk_sum  = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
  assign last_chunk = (cnt_q == CntW'(N - 1));

  // Carry into the top bit recovered from its sum: s = a ^ b ^ cin.
  assign msb_cin = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_sum[CHUNK-1];

  always_comb begin
    s_calc = s_q;
    s_calc[chunk_lsb +: CHUNK] = chunk_sum[CHUNK-1:0];
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    s_d     = s_q;
    cout_d  = cout_q;
    v_d     = v_q;
    z_d     = z_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          a_d     = A;
          b_d     = B ^ {WIDTH{sub}};
          carry_d = sub ? 1'b1 : Cin;
          cnt_d   = '0;
          state_d = StCalc;
        end else begin
          state_d = StIdle;
        end
      end
      StCalc: begin
        s_d     = s_calc;
        carry_d = chunk_sum[CHUNK];
        if (last_chunk) begin
          cout_d  = chunk_sum[CHUNK];
          v_d     = msb_cin ^ chunk_sum[CHUNK];
          z_d     = (s_calc == '0);
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      v_q     <= v_d;
      z_q     <= z_d;
    end
  end

  assign S    = s_q;
  assign Cout = cout_q;
  assign V    = v_q;
  assign Z    = z_q;
  assign busy = (state_q == StCalc);
  assign done = (state_q == StDone);

endmodule

// File: tb/tb_sirali_toplayici.sv
// Bench for sirali_toplayici: three instances (CHUNK = 4, 1, 16) with a
// scoreboard of expected results checked when each done pulse appears.
module tb_sirali_toplayici;

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        v;
    logic        z;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  start_v;
  logic        sub;
  logic        cin;
  logic [15:0] a;
  logic [15:0] b;

  logic [15:0] s_w [3];
  logic [2:0]  cout_w, v_w, z_w, busy_w, done_w;

  int errors = 0;
  int checks = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  sirali_toplayici #(.WIDTH(16), .CHUNK(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start_v[0]), .sub(sub), .Cin(cin), .A(a), .B(b),
    .S(s_w[0]), .Cout(cout_w[0]), .V(v_w[0]), .Z(z_w[0]), .busy(busy_w[0]), .done(done_w[0])
  );
  sirali_toplayici #(.WIDTH(16), .CHUNK(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .sub(sub), .Cin(cin), .A(a), .B(b),
    .S(s_w[1]), .Cout(cout_w[1]), .V(v_w[1]), .Z(z_w[1]), .busy(busy_w[1]), .done(done_w[1])
  );
  sirali_toplayici #(.WIDTH(16), .CHUNK(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start_v[2]), .sub(sub), .Cin(cin), .A(a), .B(b),
    .S(s_w[2]), .Cout(cout_w[2]), .V(v_w[2]), .Z(z_w[2]), .busy(busy_w[2]), .done(done_w[2])
  );

  function automatic int n_of(input int w);
    return (w == 0) ? 4 : ((w == 1) ? 16 : 1);
  endfunction

  // Reference: 17-bit arithmetic, overflow from operand/result signs.
  function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb,
                                 input logic msub, input logic mcin);
    exp_t        e;
    logic [15:0] bb;
    logic [16:0] full;
    bb    = msub ? ~mb : mb;
    full  = {1'b0, ma} + {1'b0, bb} + {16'd0, (msub ? 1'b1 : mcin)};
    e.s   = full[15:0];
    e.c   = full[16];
    e.v   = (ma[15] == bb[15]) && (full[15] != ma[15]);
    e.z   = (full[15:0] == 16'd0);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive a request, push its expected result, let the accept edge pass, then
  // scramble the inputs so late changes would show up as wrong results.
  task automatic issue(input int w, input logic [15:0] ia, input logic [15:0] ib,
                       input logic isub, input logic icin);
    a = ia; b = ib; sub = isub; cin = icin;
    start_v[w] = 1'b1;
    sb.push_back(model(ia, ib, isub, icin));
    @(posedge clk); #1;
    start_v[w] = 1'b0;
    a = $urandom; b = $urandom; sub = ~isub; cin = ~icin;
  endtask

  // k0 = index of the current sample (1 = first sample after the accept edge).
  task automatic wait_done(input int w, input int k0);
    int   k;
    int   busy_seen;
    int   n;
    exp_t e;
    k = k0; busy_seen = 0; n = n_of(w);
    while (!done_w[w] && k < 40) begin
      if (busy_w[w]) busy_seen++;
      @(posedge clk); #1;
      k++;
    end
    check($sformatf("latency_d%0d", w), k, n + 1);
    check($sformatf("busy_cycles_d%0d", w), busy_seen, n - (k0 - 1));
    check($sformatf("busy_at_done_d%0d", w), {31'd0, busy_w[w]}, 32'd0);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (done_w[w]) begin
        check($sformatf("S_d%0d", w), {16'd0, s_w[w]}, {16'd0, e.s});
        check($sformatf("Cout_d%0d", w), {31'd0, cout_w[w]}, {31'd0, e.c});
        check($sformatf("V_d%0d", w), {31'd0, v_w[w]}, {31'd0, e.v});
        check($sformatf("Z_d%0d", w), {31'd0, z_w[w]}, {31'd0, e.z});
      end
    end
  endtask

  task automatic run_op(input int w, input logic [15:0] ia, input logic [15:0] ib,
                        input logic isub, input logic icin);
    logic [15:0] s_done;
    logic        c_done;
    issue(w, ia, ib, isub, icin);
    wait_done(w, 1);
    s_done = s_w[w];
    c_done = cout_w[w];
    @(posedge clk); #1;
    check($sformatf("done_pulse_d%0d", w), {31'd0, done_w[w]}, 32'd0);
    check($sformatf("S_hold_d%0d", w), {16'd0, s_w[w]}, {16'd0, s_done});
    check($sformatf("Cout_hold_d%0d", w), {31'd0, cout_w[w]}, {31'd0, c_done});
  endtask

  logic [15:0] va   [8] = '{16'h1234, 16'h1234, 16'hFFFF, 16'h7FFF,
                            16'h0003, 16'h8000, 16'h00AA, 16'hA5C3};
  logic [15:0] vb   [8] = '{16'h4321, 16'h0000, 16'h0001, 16'h0001,
                            16'h0005, 16'h0001, 16'h00AA, 16'h5A3C};
  logic        vsub [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic        vcin [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    int dn;
    rst = 1'b1; start_v = 3'b111; sub = 1'b0; cin = 1'b0; a = 16'h1111; b = 16'h2222;

    // Reset held two cycles with start asserted: nothing may start.
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0; start_v = 3'b000;
    check("rst_S", {16'd0, s_w[0]}, 32'd0);
    check("rst_Cout", {31'd0, cout_w[0]}, 32'd0);
    check("rst_V", {31'd0, v_w[0]}, 32'd0);
    check("rst_Z", {31'd0, z_w[0]}, 32'd0);
    check("rst_busy", {29'd0, busy_w}, 32'd0);
    check("rst_done", {29'd0, done_w}, 32'd0);
    @(posedge clk); #1;
    check("rst_no_start_busy", {29'd0, busy_w}, 32'd0);

    // Directed vectors on every slice width.
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < 8; i++) begin
        run_op(w, va[i], vb[i], vsub[i], vcin[i]);
      end
    end

    // Start during busy is ignored; start in the done cycle is accepted.
    issue(0, 16'h1234, 16'h4321, 1'b0, 1'b0);
    @(posedge clk); #1;
    a = 16'hDEAD; b = 16'hBEEF; sub = 1'b1; start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    wait_done(0, 3);
    issue(0, 16'h0F0F, 16'hF0F0, 1'b0, 1'b1);
    wait_done(0, 1);
    @(posedge clk); #1;

    // Reset in the middle of an operation aborts it without a done pulse.
    issue(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    void'(sb.pop_front());
    check("abort_busy", {31'd0, busy_w[0]}, 32'd0);
    check("abort_S", {16'd0, s_w[0]}, 32'd0);
    check("abort_flags", {29'd0, cout_w[0], v_w[0], z_w[0]}, 32'd0);
    dn = 0;
    for (int i = 0; i < 6; i++) begin
      if (done_w[0]) dn++;
      @(posedge clk); #1;
    end
    check("abort_no_done", dn, 0);
    run_op(0, 16'h8000, 16'h0001, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
